// File: rtl/fifo_sync_param_if.sv
// Handshake bundle for fifo_sync_param; overflow/underflow exist only when
// FIFO_SYNC_ERR_FLAGS_EN is defined.
interface fifo_sync_param_if #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic                  clear;
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;
`endif

    modport master (
        output clear, push, data_in, pop,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        input  overflow, underflow,
`endif
        input  data_out, data_valid, full, empty, almost_full, almost_empty, count
    );

    modport slave (
        input  clear, push, data_in, pop,
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        output overflow, underflow,
`endif
        output data_out, data_valid, full, empty, almost_full, almost_empty, count
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO of arbitrary depth with registered read data, occupancy flags and flush.
// Define FIFO_SYNC_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module fifo_sync_param #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned AF_THRESH  = DEPTH - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input logic              clk,
    input logic              reset,
    fifo_sync_param_if.slave bus
);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  afull_q, afull_d;
    logic                  aempty_q, aempty_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  push_ok, pop_ok;

    // A push into a full FIFO is legal only when a pop frees the slot at the same edge.
    always_comb begin
        pop_ok  = bus.pop && !empty_q && !bus.clear;
        push_ok = bus.push && (!full_q || pop_ok) && !bus.clear;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = pop_ok;
        if (bus.clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
                dout_d   = mem[rd_ptr_q];
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count_d = count_q - 1'b1;
            end
        end
        // Flags follow next-count so they never lag the count output.
        full_d   = (count_d == CNT_FULL);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_LVL);
        aempty_d = (count_d <= AE_LVL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

`ifdef FIFO_SYNC_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clk) begin
        if (reset || bus.clear) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.push && !push_ok) ovf_q <= 1'b1;
            if (bus.pop && empty_q)   unf_q <= 1'b1;
        end
    end

    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
`endif

    assign bus.data_out     = dout_q;
    assign bus.data_valid   = dvalid_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.count        = count_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param (DEPTH=5, AF=4, AE=1) with a reference queue
// model and a scoreboard of expected read words.
module tb_fifo_sync_param;
    localparam int unsigned DEPTH = 5;
    localparam int unsigned DW    = 8;
    localparam int unsigned AF    = 4;
    localparam int unsigned AE    = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    fifo_sync_param #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DW),
        .AF_THRESH  (AF),
        .AE_THRESH  (AE)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  m_q[$];
    logic [7:0]  sb_q[$];
    logic        exp_dv  = 1'b0;
    logic        exp_rst = 1'b0;
    logic [7:0]  m_dout  = 8'h00;
    logic        m_ovf   = 1'b0;
    logic        m_unf   = 1'b0;
    logic        mon_en  = 1'b0;

    // Drive one cycle of stimulus, advance the model, and return at the active edge.
    task automatic step(input logic p, input logic [7:0] d, input logic q, input logic c,
                        input logic r);
        logic pok, wok;
        #2;
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
        bus.clear   = c;
        rst         = r;
        pok = q && (m_q.size() != 0);
        wok = p && ((m_q.size() < DEPTH) || pok);
        exp_rst = r;
        if (r || c) begin
            m_q.delete();
            sb_q.delete();
            exp_dv = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            if (p && !wok) m_ovf = 1'b1;
            if (q && m_q.size() == 0) m_unf = 1'b1;
            exp_dv = pok;
            if (pok) sb_q.push_back(m_q.pop_front());
            if (wok) m_q.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) step(1'b1, 8'(base + 8'(i)), 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Scoreboard monitor: compares every cycle against the model.
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (exp_rst) m_dout = 8'h00;
            n_checks++;
            if (bus.data_valid !== exp_dv) begin
                n_fail++;
                $display("FAIL sb_valid: got %b want %b at %0t", bus.data_valid, exp_dv, $time);
            end
            if (exp_dv) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underrun: no expected word at %0t", $time);
                end else begin
                    m_dout = sb_q.pop_front();
                    if (bus.data_out !== m_dout) begin
                        n_fail++;
                        $display("FAIL sb_data: got %h want %h at %0t", bus.data_out, m_dout,
                                 $time);
                    end
                end
            end else begin
                n_checks++;
                if (bus.data_out !== m_dout) begin
                    n_fail++;
                    $display("FAIL sb_hold: got %h want %h at %0t", bus.data_out, m_dout, $time);
                end
            end
            n_checks++;
            if (bus.count !== 3'(m_q.size()) || bus.full !== (m_q.size() == DEPTH) ||
                bus.empty !== (m_q.size() == 0) || bus.almost_full !== (m_q.size() >= AF) ||
                bus.almost_empty !== (m_q.size() <= AE)) begin
                n_fail++;
                $display("FAIL sb_flags: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d at %0t",
                         bus.count, bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                         m_q.size(), $time);
            end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
            n_checks++;
            if (bus.overflow !== m_ovf || bus.underflow !== m_unf) begin
                n_fail++;
                $display("FAIL sb_err: got ovf=%b unf=%b want ovf=%b unf=%b", bus.overflow,
                         bus.underflow, m_ovf, m_unf);
            end
`endif
        end
    end

    task automatic test_reset();
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got cnt=%0d e=%b f=%b want 0 1 0", bus.count,
                     bus.empty, bus.full);
        end
        n_checks++;
        if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_thresh: got ae=%b af=%b want 1 0", bus.almost_empty,
                     bus.almost_full);
        end
        n_checks++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dout: got %h/%b want 00/0", bus.data_out, bus.data_valid);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] w;
        fill(8'h11, 5);
        #1;
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 3'd5) begin
            n_fail++;
            $display("FAIL fill_full: got f=%b cnt=%0d want 1 5", bus.full, bus.count);
        end
        for (int i = 0; i < 5; i++) begin
            w = 8'(8'h11 + 8'(i));
            drain(1);
            #1;
            n_checks++;
            if (bus.data_valid !== 1'b1 || bus.data_out !== w) begin
                n_fail++;
                $display("FAIL drain_word: got %h/%b want %h/1", bus.data_out, bus.data_valid, w);
            end
        end
        fill(8'hA1, 3);
        for (int i = 0; i < 3; i++) begin
            w = 8'(8'hA1 + 8'(i));
            drain(1);
            #1;
            n_checks++;
            if (bus.data_out !== w) begin
                n_fail++;
                $display("FAIL wrap_word: got %h want %h", bus.data_out, w);
            end
        end
    endtask

    task automatic test_thresholds();
        logic e_ae, e_af, e_f;
        #1;
        n_checks++;
        if (bus.almost_empty !== 1'b1) begin
            n_fail++;
            $display("FAIL thr_ae0: got %b want 1", bus.almost_empty);
        end
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 8'(8'h20 + 8'(i)), 1'b0, 1'b0, 1'b0);
            #1;
            e_ae = (i <= 1);
            e_af = (i >= 4);
            e_f  = (i == 5);
            n_checks++;
            if (bus.almost_empty !== e_ae || bus.almost_full !== e_af || bus.full !== e_f) begin
                n_fail++;
                $display("FAIL thr_cnt%0d: got ae=%b af=%b f=%b want %b %b %b", i,
                         bus.almost_empty, bus.almost_full, bus.full, e_ae, e_af, e_f);
            end
        end
        drain(5);
    endtask

    task automatic test_simultaneous();
        fill(8'h01, 5);
        step(1'b1, 8'h66, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.data_out !== 8'h01 || bus.count !== 3'd5 || bus.data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop: got %h cnt=%0d v=%b want 01 5 1", bus.data_out,
                     bus.count, bus.data_valid);
        end
        drain(5);
        #1;
        n_checks++;
        if (bus.data_out !== 8'h66) begin
            n_fail++;
            $display("FAIL full_pushpop_5th: got %h want 66", bus.data_out);
        end
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.data_valid !== 1'b0 || bus.count !== 3'd1) begin
            n_fail++;
            $display("FAIL empty_pushpop: got v=%b cnt=%0d want 0 1", bus.data_valid, bus.count);
        end
        drain(1);
    endtask

    task automatic test_illegal();
        fill(8'h31, 5);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== 3'd5 || bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL overflow_push: got cnt=%0d v=%b want 5 0", bus.count, bus.data_valid);
        end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_flag: got %b want 1", bus.overflow);
        end
`endif
        drain(5);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.data_valid !== 1'b0 || bus.data_out !== 8'h35) begin
            n_fail++;
            $display("FAIL underflow_pop: got cnt=%0d v=%b d=%h want 0 0 35", bus.count,
                     bus.data_valid, bus.data_out);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        #1;
        n_checks++;
        if (bus.overflow !== 1'b1 || bus.underflow !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got ovf=%b unf=%b want 1 1", bus.overflow, bus.underflow);
        end
`endif
    endtask

    task automatic test_clear_reset();
        logic [7:0] held;
        fill(8'h51, 3);
        #1;
        held = m_dout;
        step(1'b1, 8'hEE, 1'b1, 1'b1, 1'b0);
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.data_valid !== 1'b0 ||
            bus.data_out !== held) begin
            n_fail++;
            $display("FAIL clear_state: got cnt=%0d e=%b v=%b d=%h want 0 1 0 %h", bus.count,
                     bus.empty, bus.data_valid, bus.data_out, held);
        end
`ifdef FIFO_SYNC_ERR_FLAGS_EN
        n_checks++;
        if (bus.overflow !== 1'b0 || bus.underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_err: got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow);
        end
`endif
        fill(8'h42, 1);
        drain(1);
        #1;
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h42) begin
            n_fail++;
            $display("FAIL clear_refill: got %h/%b want 42/1", bus.data_out, bus.data_valid);
        end
        fill(8'h61, 3);
        step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        #1;
        n_checks++;
        if (bus.count !== 3'd0 || bus.data_out !== 8'h00 || bus.data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got cnt=%0d d=%h v=%b want 0 00 0", bus.count,
                     bus.data_out, bus.data_valid);
        end
        fill(8'h42, 1);
        drain(1);
        #1;
        n_checks++;
        if (bus.data_out !== 8'h42) begin
            n_fail++;
            $display("FAIL reset_refill: got %h want 42", bus.data_out);
        end
    endtask

    initial begin
        mon_en = 1'b1;
        test_reset();
        test_fill_drain();
        test_thresholds();
        test_simultaneous();
        test_illegal();
        test_clear_reset();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic push/pop FIFO.
- Adds:
  - arbitrary (non-power-of-2) depth with explicit pointer wrap
  - occupancy count output
  - programmable almost-full and almost-empty thresholds
  - registered read data with a valid strobe
  - synchronous flush
  - defined behaviour for simultaneous push/pop at full and empty
- Sits between producer/consumer stages of a datapath, e.g. to buffer bursts between modules.

Parameters:
- DEPTH, 16, number of entries; legal range 2..1024, need not be a power of 2.
- DATA_WIDTH, 8, width of each entry in bits.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous flush; empties the FIFO and does not touch memory contents.
- push  input  1  write request.
- data_in  input  DATA_WIDTH  write data, sampled when a push is accepted.
- pop  input  1  read request.
- data_out  output  DATA_WIDTH  read data, registered.
- data_valid  output  1  high for exactly one cycle when data_out carries a newly popped word.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Reset (sync, active-high, highest priority):
  - wr_ptr=0, rd_ptr=0, count=0
  - empty=1, full=0
  - almost_empty=1, almost_full=0
  - data_out=0, data_valid=0
  - Memory array is not reset.
- Clear (priority below reset, above push/pop):
  - Same register effect as reset, except data_out holds its value.
  - data_valid=0.
  - push and pop in the same cycle are ignored.
- Pointers:
  - Width $clog2(DEPTH).
  - Increment and wrap from DEPTH-1 to 0 by explicit compare; never rely on natural binary overflow.
- Accept rules, evaluated on the registered state at the clock edge:
  - pop_ok = pop && !empty.
  - push_ok = push && (!full || pop_ok).
  - Full with push+pop: both accepted; count stays DEPTH; the oldest word is read and the new word is written.
  - Empty with push+pop: only the push is accepted. There is no bypass. count becomes 1 and data_valid=0.
  - Push while full without pop: dropped; no state change.
  - Pop while empty: ignored; data_valid=0.
- Write: on push_ok, mem[wr_ptr] <= data_in and wr_ptr advances.
- Read:
  - On pop_ok, data_out <= mem[rd_ptr], rd_ptr advances, and data_valid=1 on the next cycle.
  - Read latency is 1 cycle from the accepting edge.
  - data_out holds its last value when no pop is accepted.
- count: next = count + push_ok - pop_ok.
- Flags: all flags are registered and derived from next-count, so they are coherent with count in the same cycle. There are no combinational paths from inputs to outputs.
- A flush or reset in the middle of a burst discards all stored words. The first pop after a refill returns the first word written after the flush.

Optional Feature:
- Macro: FIFO_SYNC_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - overflow (1 bit): sticky; set on push && !push_ok.
  - underflow (1 bit): sticky; set on pop && empty.
- Both sticky flags clear only on reset or clear; reset value is 0.
- When not defined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
All scenarios use DEPTH=5, DATA_WIDTH=8, AF_THRESH=4, AE_THRESH=1.
1. Fill and drain with wrap:
   - Stimulus: push 0x11..0x15 (5 cycles); then pop 5 times; then push 0xA1..0xA3 and pop 3.
   - Required: full=1 and count=5 after the 5th push. Outputs 0x11..0x15 each 1 cycle after the pop, with data_valid pulses. After the pointers wrap past index 4, 0xA1..0xA3 come out in order.
2. Threshold flags:
   - Stimulus: push one word per cycle from empty.
   - Required:
     - almost_empty=1 at count 0 and 1; it drops when count=2.
     - almost_full rises when count=4.
     - full rises at count=5.
3. Simultaneous push and pop at the boundaries:
   - When full with data 0x01..0x05, push 0x66 with pop: data_out=0x01, count stays 5, and 0x66 is popped 5th.
   - When empty, push 0x77 with pop: data_valid=0 and count=1.
4. Illegal access:
   - Stimulus: push 0x99 while full without pop; pop while empty.
   - Required: no change in count or contents; data_valid=0. With FIFO_SYNC_ERR_FLAGS_EN, overflow=1 and underflow=1, and they stay set until clear.
5. Clear and reset mid-operation:
   - Stimulus: with count=3, assert clear together with push and pop.
   - Required next cycle: count=0, empty=1, data_valid=0, and data_out unchanged. Then push 0x42 and pop, and 0x42 is returned.
   - Repeat with reset: data_out must become 0.
